// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - eight-source interrupt controller with per-bit mode/polarity and priority vector
module irq_ctrl #(
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       we_n,
    input  logic [2:0] rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] irq_src,
    output logic       irq_n
);

    localparam logic [2:0] RS_PENDING = 3'd0;
    localparam logic [2:0] RS_MASK    = 3'd1;
    localparam logic [2:0] RS_MODE    = 3'd2;
    localparam logic [2:0] RS_POL     = 3'd3;
    localparam logic [2:0] RS_ACTIVE  = 3'd4;
    localparam logic [2:0] RS_VECTOR  = 3'd5;
    localparam logic [2:0] RS_SWSET   = 3'd6;

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_sync3;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    logic [7:0] r_mode;
    logic [7:0] r_pol;
    logic [7:0] r_dout;
    logic       r_irq_n;

    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_act2;
    logic [7:0] w_act3;
    logic [7:0] w_edge;
    logic [7:0] w_clr;
    logic [7:0] w_swset;
    logic [7:0] w_active;
    logic [7:0] w_vector;
    logic [7:0] w_pending_nxt;
    logic [7:0] w_rdata;

    assign w_wr = ~cs_n & ~we_n;
    assign w_rd = ~cs_n &  we_n;

    // Both history taps use the current POL, so a POL write alone cannot create an edge.
    assign w_act2 = r_sync2 ^ ~r_pol;
    assign w_act3 = r_sync3 ^ ~r_pol;
    assign w_edge = w_act2 & ~w_act3;

    assign w_clr   = (w_wr && rs == RS_PENDING) ? din : 8'h00;
    assign w_swset = (w_wr && rs == RS_SWSET)   ? din : 8'h00;

    assign w_active = r_pending & r_mask;

    // Set terms are OR-ed after the clear so a coincident edge or swset wins.
    assign w_pending_nxt = (r_mode  & ((r_pending & ~w_clr) | w_edge | w_swset))
                         | (~r_mode & w_act2);

    always_comb begin
        w_vector = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vector = {1'b1, 4'b0000, 3'(i)};
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (rs)
            RS_PENDING: w_rdata = r_pending;
            RS_MASK:    w_rdata = r_mask;
            RS_MODE:    w_rdata = r_mode;
            RS_POL:     w_rdata = r_pol;
            RS_ACTIVE:  w_rdata = w_active;
            RS_VECTOR:  w_rdata = w_vector;
            default:    w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 8'hFF;
            r_sync2   <= 8'hFF;
            r_sync3   <= 8'hFF;
            r_pending <= 8'h00;
            r_mask    <= RESET_MASK;
            r_mode    <= 8'h00;
            r_pol     <= 8'h00;
            r_dout    <= 8'h00;
            r_irq_n   <= 1'b1;
        end else begin
            r_sync1   <= irq_src;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_pending <= w_pending_nxt;
            r_irq_n   <= ~|w_active;
            if (w_rd) begin
                r_dout <= w_rdata;
            end
            if (w_wr) begin
                case (rs)
                    RS_MASK: r_mask <= din;
                    RS_MODE: r_mode <= din;
                    RS_POL:  r_pol  <= din;
                    default: ;
                endcase
            end
        end
    end

    assign dout  = r_dout;
    assign irq_n = r_irq_n;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Eight-source interrupt controller for the 6502 SoC. It collects peripheral and external interrupt lines and synchronises each one. It latches or tracks each line according to a per-source mode and polarity. It drives a single registered active-low request into the CPU IRQ_n input, and the CPU reads a priority vector to find the source. It is a CPU-mapped peripheral on the page-1 I/O decode, with the same cs_n/we_n/rs/din/dout bus protocol and one-cycle registered read data as the other peripherals.

## Interface
- RESET_MASK, 8'h00, value loaded into MASK on reset.
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select, active low.
- we_n  in  1  write enable, active low; valid with cs_n.
- rs  in  3  register select (CPU_AB[2:0]).
- din  in  8  write data from CPU.
- dout  out  8  registered read data.
- irq_src  in  8  raw interrupt inputs, asynchronous to clk.
- irq_n  out  1  registered combined request to CPU, active low.

## Operation
- Registers (rs):
  - 0 PENDING: R returns pending[7:0]. W-1-to-clear, applies to edge-mode bits only.
  - 1 MASK: R/W, 1 = enabled.
  - 2 MODE: R/W, 1 = edge (latched), 0 = level (tracks input).
  - 3 POL: R/W, 1 = active-high, 0 = active-low.
  - 4 ACTIVE: RO, pending & mask.
  - 5 VECTOR: RO.
    - bit7 = |ACTIVE; bits2:0 = index of lowest-numbered ACTIVE bit; bits6:3 = 0.
    - Reads 8'h00 when nothing is active.
    - Reading has no side effects.
  - 6 SWSET: W-1-to-set pending on edge-mode bits; level-mode bits ignored. Reads 8'h00.
  - 7: reads 8'h00, writes ignored.
- Input path, per bit:
  - Two-flop synchroniser sync1 → sync2, plus history flop sync3.
  - act(x) = POL ? x : ~x.
  - edge = act(sync2) & ~act(sync3), evaluated with the current POL on both terms, so a POL write never fabricates an edge.
- Pending update, every clock:
  - Level mode: pending <= act(sync2).
  - Edge mode: pending <= (pending & ~clr) | edge | swset.
  - clr and swset are the masked write strobes of this cycle. Set wins over a simultaneous clear.
- MODE change: pending keeps its current value. After a level→edge switch the bit stays set until cleared.
- irq_n <= ~|(pending & mask), evaluated from the pending value before the update on the same edge.
- Write: on a rising edge with cs_n=0 and we_n=0, the register at rs is updated from din.
- Read:
  - On a rising edge with cs_n=0 and we_n=1, dout <= register[rs], using pre-edge state.
  - dout holds when cs_n=1 or on writes.
- Reset (asynchronous assert) sets:
  - pending=0, MASK=RESET_MASK, MODE=0, POL=0.
  - sync1/sync2/sync3=8'hFF (inactive for active-low).
  - dout=8'h00, irq_n=1.
- Reset mid-operation discards all pending state. No request survives reset.

## Timing
- Read latency: address at edge N, data valid on dout after edge N, so the CPU mux samples it in cycle N+1.
- Input path: irq_src active and stable before edge E1.
  - sync1 after E1, sync2 after E2, pending after E3.
  - irq_n low after E4 if masked in.
- MASK write at edge W: irq_n reflects the new mask after W+1.
- PENDING clear at edge W: pending=0 after W. irq_n=1 after W+1 if no other source is active.
  - If a new edge arrives on the same cycle, the bit stays 1.
- Level source deasserts before E1: pending clears after E3, irq_n=1 after E4.
- Edge pulses must be at least 2 clk wide to be guaranteed. Shorter pulses may be missed.
- Repeated edges while a bit is already pending merge into one pending.

## Test plan
- Reset: assert reset_n=0 mid-traffic → irq_n=1, dout=00, MASK reads 00, PENDING reads 00, sync state inactive.
- Edge latch: MODE=FF, MASK=04, POL=00. Drive irq_src[2] 1→0 for 3 cycles then back to 1.
  - irq_n=0 exactly 4 edges after the fall.
  - PENDING=04, VECTOR=82.
  - Write PENDING=04 → irq_n=1 two edges later.
- Level track: MODE=00, POL=FF, MASK=81, irq_src=81.
  - VECTOR=80 (bit0 wins).
  - Drop irq_src[0] → VECTOR=87.
  - Drop irq_src[7] → irq_n=1 after 4 edges.
- Set-over-clear: edge source 5 pending. Write PENDING=20 on the same cycle a new edge is detected → PENDING still 20, irq_n stays 0.
- POL toggle: static irq_src=00 with POL=00 pending cleared. Write POL=FF → no edge recorded in edge mode, PENDING=00.
- SWSET: MODE=0F, MASK=FF, write SWSET=FF → PENDING=0F, ACTIVE=0F, VECTOR=80. Reg 7 reads 00.
